// File: rtl/cnt_capture_if.sv
// ---------------------------------------------------------------------------
// cnt_capture_if
//   Timestamp stream between cnt_capture (master) and its consumer (slave).
//   out_valid : head of the capture FIFO holds a timestamp
//   out_ready : consumer accepts the head on the next rising edge
//   out_data  : head timestamp, {ext, cnt}, EXT_W+16 bits
// ---------------------------------------------------------------------------
interface cnt_capture_if #(
  parameter int EXT_W = 8
);
  logic               out_valid;
  logic               out_ready;
  logic [EXT_W+15:0]  out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/cnt_capture.sv
// ---------------------------------------------------------------------------
// cnt_capture
//   Timestamps rising edges of an asynchronous event line against an
//   upstream 16-bit free-running counter, extended by a local wrap counter,
//   and queues the stamps in a first-word-fall-through FIFO.
//
//   Ports
//     clk       : clock, all state on the rising edge
//     rst       : asynchronous active-high reset
//     cnt_en    : upstream counter enable (observed only)
//     cnt_dout  : upstream counter value
//     cnt_cout  : upstream terminal-count flag (cnt_dout == 16'hFFFF)
//     evt_in    : asynchronous event line
//     clr_ovr   : synchronous pulse clearing ovr
//     lvl       : FIFO occupancy, 0..DEPTH
//     ovr       : sticky "event dropped" flag
//     ts        : timestamp stream (out_valid / out_ready / out_data)
// ---------------------------------------------------------------------------
module cnt_capture #(
  parameter int DEPTH = 4,   // power of two, 2..16
  parameter int EXT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cnt_en,
  input  logic [15:0]            cnt_dout,
  input  logic                   cnt_cout,
  input  logic                   evt_in,
  input  logic                   clr_ovr,
  output logic [$clog2(DEPTH):0] lvl,
  output logic                   ovr,
  cnt_capture_if.master          ts
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            SW   = EXT_W + 16;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  // Event synchronizer and edge history
  logic s1, s2, s3;
  logic detect;

  // Wrap-extension counter
  logic [EXT_W-1:0] ext;
  logic             wrap;

  // FIFO
  logic [SW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           push, pop, drop, full;

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers sample the pre-edge values of each other, matching hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Rising edge of the synchronized event only.
  assign detect = s2 & ~s3;

  // The upstream counter rolls over to 0 on this edge.
  assign wrap = cnt_en & cnt_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ext <= '0;
    else     ext <= ext + EXT_W'(wrap);
  end

  assign full         = (lvl == FULL);
  assign ts.out_valid = (lvl != '0);
  assign pop          = ts.out_valid & ts.out_ready;
  // A full FIFO still accepts a stamp when the head leaves on the same edge.
  assign push         = detect & (~full | pop);
  assign drop         = detect & full & ~pop;

  // Gating on out_valid keeps out_data at 0 through reset even though the
  // storage itself is never cleared.
  assign ts.out_data  = ts.out_valid ? mem[rptr] : '0;

  // NOTE: the storage array has no reset; its contents are only visible
  // through out_data while lvl != 0, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {ext, cnt_dout};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovr <= 1'b0;
    else if (drop)    ovr <= 1'b1;
    else if (clr_ovr) ovr <= 1'b0;
  end

endmodule

// File: tb/tb_cnt_capture.sv
// ---------------------------------------------------------------------------
// tb_cnt_capture
//   Directed self-checking bench for cnt_capture with DEPTH=4, EXT_W=8.
// ---------------------------------------------------------------------------
module tb_cnt_capture;

  localparam int DEPTH = 4;
  localparam int EXT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_en;
  logic [15:0] cnt_dout;
  logic        cnt_cout;
  logic        evt_in;
  logic        clr_ovr;
  logic [2:0]  lvl;
  logic        ovr;

  int tests = 0;
  int fails = 0;

  cnt_capture_if #(.EXT_W(EXT_W)) ts_if ();

  cnt_capture #(.DEPTH(DEPTH), .EXT_W(EXT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .cnt_dout (cnt_dout),
    .cnt_cout (cnt_cout),
    .evt_in   (evt_in),
    .clr_ovr  (clr_ovr),
    .lvl      (lvl),
    .ovr      (ovr),
    .ts       (ts_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle event pulse; the stamp lands on the third edge with cnt_dout=c.
  // rdy is the consumer ready during that third (detect) cycle.
  task automatic capture(input logic [15:0] c, input logic rdy);
    cnt_dout = c;
    evt_in   = 1'b1;
    tick();
    evt_in   = 1'b0;
    tick();
    ts_if.out_ready = rdy;
    tick();
    ts_if.out_ready = 1'b0;
  endtask

  task automatic pop_one();
    ts_if.out_ready = 1'b1;
    tick();
    ts_if.out_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    cnt_en          = 1'b0;
    cnt_dout        = 16'h0000;
    cnt_cout        = 1'b0;
    evt_in          = 1'b0;
    clr_ovr         = 1'b0;
    ts_if.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_lvl",   32'(lvl), 32'd0);
    check("rst_ovr",   32'(ovr), 32'd0);
    check("rst_valid", 32'(ts_if.out_valid), 32'd0);
    check("rst_data",  32'(ts_if.out_data), 32'h0);
    #10 rst = 1'b0;

    // Single 3-cycle pulse, latency N+2
    cnt_dout = 16'h0010;
    evt_in   = 1'b1;
    tick();
    check("lat_n",  32'(ts_if.out_valid), 32'd0);
    tick();
    check("lat_n1", 32'(ts_if.out_valid), 32'd0);
    tick();
    evt_in = 1'b0;
    check("lat_n2_valid", 32'(ts_if.out_valid), 32'd1);
    check("lat_n2_lvl",   32'(lvl), 32'd1);
    check("lat_n2_data",  32'(ts_if.out_data), 32'h000010);
    tick(4);
    check("one_capture_only", 32'(lvl), 32'd1);
    check("hold_data",        32'(ts_if.out_data), 32'h000010);
    pop_one();
    check("pop_lvl",   32'(lvl), 32'd0);
    check("pop_valid", 32'(ts_if.out_valid), 32'd0);

    // Detect coincides with wrap: pre-increment ext, then ext+1
    cnt_en   = 1'b1;
    cnt_dout = 16'hFFFE;
    evt_in   = 1'b1;
    tick();
    evt_in   = 1'b0;
    tick();
    cnt_dout = 16'hFFFF;
    cnt_cout = 1'b1;
    tick();
    cnt_dout = 16'h0000;
    cnt_cout = 1'b0;
    check("wrap_stamp", 32'(ts_if.out_data), 32'h00FFFF);
    capture(16'h0000, 1'b0);
    cnt_en = 1'b0;
    check("wrap_lvl", 32'(lvl), 32'd2);
    check("wrap_head0", 32'(ts_if.out_data), 32'h00FFFF);
    pop_one();
    check("wrap_head1", 32'(ts_if.out_data), 32'h010000);
    pop_one();
    check("wrap_drain", 32'(lvl), 32'd0);

    // Overflow: 5 events into a 4-deep FIFO
    for (int i = 0; i < 4; i++) capture(16'h0100 + 16'(i), 1'b0);
    check("fill_lvl", 32'(lvl), 32'd4);
    check("fill_ovr", 32'(ovr), 32'd0);
    capture(16'h0104, 1'b0);
    check("drop_lvl",  32'(lvl), 32'd4);
    check("drop_ovr",  32'(ovr), 32'd1);
    check("drop_head", 32'(ts_if.out_data), 32'h010100);
    tick(3);
    check("ovr_sticky", 32'(ovr), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("clr_ovr", 32'(ovr), 32'd0);

    // Full FIFO with pop and push on the same edge
    capture(16'h0105, 1'b1);
    check("full_pp_lvl",  32'(lvl), 32'd4);
    check("full_pp_ovr",  32'(ovr), 32'd0);
    check("order_0", 32'(ts_if.out_data), 32'h010101);
    pop_one();
    check("order_1", 32'(ts_if.out_data), 32'h010102);
    pop_one();
    check("order_2", 32'(ts_if.out_data), 32'h010103);
    pop_one();
    check("order_3", 32'(ts_if.out_data), 32'h010105);
    pop_one();
    check("order_drain", 32'(lvl), 32'd0);

    // ext is 1 here; 255 wraps bring it back to 0. cnt_cout without cnt_en
    // must not count.
    cnt_en   = 1'b1;
    cnt_cout = 1'b1;
    tick(255);
    cnt_en   = 1'b0;
    tick(3);
    cnt_cout = 1'b0;
    capture(16'h1234, 1'b0);
    check("ext_mod_a", 32'(ts_if.out_data), 32'h001234);
    pop_one();
    cnt_en   = 1'b1;
    cnt_cout = 1'b1;
    tick(256);
    cnt_en   = 1'b0;
    cnt_cout = 1'b0;
    capture(16'h5678, 1'b0);
    check("ext_mod_b", 32'(ts_if.out_data), 32'h005678);
    pop_one();
    check("ext_drain", 32'(lvl), 32'd0);

    // Mid-operation reset with lvl=3, ovr=1, ext=3 and evt_in held high
    cnt_en   = 1'b1;
    cnt_cout = 1'b1;
    tick(3);
    cnt_en   = 1'b0;
    cnt_cout = 1'b0;
    for (int i = 0; i < 4; i++) capture(16'h0200 + 16'(i), 1'b0);
    capture(16'h0204, 1'b0);
    pop_one();
    check("pre_rst_lvl",  32'(lvl), 32'd3);
    check("pre_rst_ovr",  32'(ovr), 32'd1);
    check("pre_rst_head", 32'(ts_if.out_data), 32'h030201);
    cnt_dout = 16'h00AA;
    evt_in   = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_lvl",   32'(lvl), 32'd0);
    check("arst_ovr",   32'(ovr), 32'd0);
    check("arst_valid", 32'(ts_if.out_valid), 32'd0);
    check("arst_data",  32'(ts_if.out_data), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("post_rst_e2", 32'(lvl), 32'd0);
    tick();
    check("post_rst_e3_lvl",  32'(lvl), 32'd1);
    check("post_rst_e3_data", 32'(ts_if.out_data), 32'h0000AA);
    tick(4);
    check("post_rst_single", 32'(lvl), 32'd1);
    evt_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnt_capture.md
CNT_CAPTURE -- requirements
Module: cnt_capture

Interface
REQ-001 Parameter DEPTH, default 4, is the number of capture FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter EXT_W, default 8, is the width of the wrap-extension counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port cnt_en, input, 1 bit: the enable driven into the upstream 16-bit counter.
REQ-006 Port cnt_dout, input, 16 bits: the upstream counter value.
REQ-007 Port cnt_cout, input, 1 bit: the upstream terminal-count flag, high while cnt_dout==16'hFFFF.
REQ-008 Port evt_in, input, 1 bit: the asynchronous external event line.
REQ-009 Port out_ready, input, 1 bit: consumer ready.
REQ-010 Port clr_ovr, input, 1 bit: synchronous pulse that clears the ovr flag.
REQ-011 Port out_valid, output, 1 bit: the FIFO head holds a timestamp.
REQ-012 Port out_data, output, EXT_W+16 bits: the head timestamp, laid out as {ext, cnt}.
REQ-013 Port lvl, output, log2(DEPTH)+1 bits: the FIFO occupancy.
REQ-014 Port ovr, output, 1 bit: sticky flag that is set when an event was dropped.

Function
REQ-015 evt_in shall pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; an edge is detected in the cycle where s2=1 and s3=0.
REQ-016 Only rising edges shall be captured; falling edges and a held-high level produce no capture.
REQ-017 The wrap counter ext shall increment by 1 on every clock edge where cnt_en=1 and cnt_cout=1, because the upstream counter wraps to 0 at that edge.
REQ-018 ext shall wrap modulo 2^EXT_W, so 2^EXT_W-1 goes to 0 with no flag.
REQ-019 On a detect cycle, the stamp pushed shall be {ext, cnt_dout} as sampled in that same cycle, using the pre-increment values.
REQ-020 When detect coincides with a wrap (cnt_en=1, cnt_cout=1), the stamp shall be {ext_old, 16'hFFFF}; the next stamp uses ext_old+1.
REQ-021 The FIFO shall be first-word-fall-through: out_valid=(lvl!=0), and out_data shows the oldest entry combinationally from storage.
REQ-022 A pop shall occur on a clock edge where out_valid=1 and out_ready=1.
REQ-023 out_data shall be held stable while out_valid=1 and out_ready=0.
REQ-024 A push shall occur on a detect cycle when lvl<DEPTH, or when lvl==DEPTH and a pop occurs in the same cycle.
REQ-025 On simultaneous push and pop, lvl shall be unchanged and ordering preserved.
REQ-026 When lvl==DEPTH with no pop and detect=1, the event shall be dropped, the FIFO left untouched, and ovr set to 1.
REQ-027 ovr shall stay at 1 until a cycle with clr_ovr=1 and no drop; if a drop and clr_ovr coincide, ovr shall be 1 (set wins).
REQ-028 Latency: when evt_in is first sampled high at edge N with the FIFO empty, out_valid shall be 1 after edge N+2.
REQ-029 Read and write pointers shall be log2(DEPTH) bits wide and wrap naturally.
REQ-030 lvl shall range from 0 to DEPTH.
REQ-031 The block shall never drive the upstream counter; cnt_en is observed only.

Reset
REQ-032 While rst=1, the following shall hold asynchronously: s1=s2=s3=0, ext=0, pointers=0, lvl=0, out_valid=0, ovr=0.
REQ-033 out_data shall be 0 during reset, and FIFO storage need not be cleared.
REQ-034 Asserting rst mid-operation shall discard all queued stamps and the wrap count immediately; the first edge after release shall see s3=0, so an evt_in held high through reset shall produce one capture 2 edges after rst falls.

Verification
REQ-035 Reset, then one evt_in pulse (3 cycles high) with cnt_dout=16'h0010 and ext=0 at detect -> one stamp 24'h000010, out_valid at N+2, lvl=1.
REQ-036 cnt_en=1 and cnt_dout stepping through FFFE, FFFF, 0000 with detect on the FFFF cycle -> stamp 24'h00FFFF; a following detect at 0000 -> 24'h010000.
REQ-037 out_ready=0, 5 events -> lvl=4, ovr=1, first 4 stamps retained in order; clr_ovr pulse -> ovr=0.
REQ-038 lvl=4, out_ready=1 and detect in the same cycle -> push accepted, lvl stays 4, ovr stays 0.
REQ-039 Force 256 wraps with cnt_en=1 -> ext returns to 0 and the next stamp's upper byte is 8'h00.
REQ-040 rst pulsed with lvl=3 and evt_in held high -> lvl=0 and ovr=0 at once; one capture 2 edges after release.
